ram_arbiter: RTL and testbench

- Shares one single-port, word-addressed Avalon RAM slave between two Avalon masters.
- M0 is the instruction fetch port. M1 is the data load/store port.
- Selects one master per cycle, stalls the other with waitrequest, and routes the 1-cycle-latency read data back to the master that issued the read.
- Sits between the core's bus ports and the RAM instance.

---
 rtl/ram_bus_pkg.sv | 22 ++
 rtl/rr_grant2.sv | 74 +++++++
 rtl/ram_arbiter.sv | 121 ++++++++++++
 tb/tb_ram_arbiter.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/ram_bus_pkg.sv
// Shared definitions for the two-master RAM arbiter: bus widths, master
// indices and the request bundle that gets muxed onto the RAM port.
package ram_bus_pkg;

  localparam int unsigned ADDR_W_DEF = 24;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned BE_W       = 4;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

  // Request bundle; the address field is ADDR_W_DEF wide, so the arbiter
  // carries at most ADDR_W_DEF address bits through the mux.
  typedef struct packed {
    logic [ADDR_W_DEF-1:0] addr;
    logic [BE_W-1:0]       byteen;
    logic                  read;
    logic                  write;
    logic [DATA_W-1:0]     wdata;
  } req_t;

endpackage

// File: rtl/rr_grant2.sv
// Two-input grant logic.
//   clk, rst_n         : clock, async active-low reset
//   req0, req1         : master requests
//   ram_wait           : RAM stall; a grant only counts as accepted when low
//   grant0_c, grant1_c : combinational one-hot (or zero) grant
// Round-robin mode alternates on contention using last_grant; fixed mode
// favours M1 but hands M0 the bus after MAX_CONSEC back-to-back M1 wins.
module rr_grant2
  import ram_bus_pkg::*;
#(
  parameter int unsigned FIXED_PRIO = 0,
  parameter int unsigned MAX_CONSEC = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req0,
  input  logic req1,
  input  logic ram_wait,
  output logic grant0_c,
  output logic grant1_c
);

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_CONSEC);

  logic             last_grant_q, last_grant_d;
  logic [CNT_W-1:0] consec_cnt_q, consec_cnt_d;
  logic             accept_c;

  // Grant selection
  always_comb begin
    grant0_c = 1'b0;
    grant1_c = 1'b0;
    if (req0 && req1) begin
      if (FIXED_PRIO != 0) begin
        if (consec_cnt_q == CNT_MAX) grant0_c = 1'b1;
        else                         grant1_c = 1'b1;
      end else begin
        if (last_grant_q == M1) grant0_c = 1'b1;
        else                    grant1_c = 1'b1;
      end
    end else begin
      grant0_c = req0;
      grant1_c = req1;
    end
  end

  assign accept_c = (grant0_c | grant1_c) & ~ram_wait;

  // Arbitration state update; a stalled grant leaves everything untouched
  always_comb begin
    last_grant_d = last_grant_q;
    consec_cnt_d = consec_cnt_q;
    if (accept_c) last_grant_d = grant1_c ? M1 : M0;
    if (!req0) begin
      consec_cnt_d = '0;
    end else if (accept_c && grant0_c) begin
      consec_cnt_d = '0;
    end else if (accept_c && grant1_c && (consec_cnt_q != CNT_MAX)) begin
      consec_cnt_d = consec_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= M1;
      consec_cnt_q <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      consec_cnt_q <= consec_cnt_d;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Shares one single-port, word-addressed Avalon RAM slave between an
// instruction-fetch master (M0) and a load/store master (M1).
//   i_Clk, i_Rst_n      : clock, async active-low reset
//   i_M0_* / o_M0_*     : fetch master port
//   i_M1_* / o_M1_*     : load/store master port
//   o_Ram_* / i_Ram_*   : RAM slave port (read data 1 cycle after accept)
// The granted master's request passes combinationally to the RAM; read data
// is steered back to whichever master issued the read one cycle earlier.
module ram_arbiter
  import ram_bus_pkg::*;
#(
  parameter int unsigned ADDR_W     = ADDR_W_DEF,
  parameter int unsigned FIXED_PRIO = 0,
  parameter int unsigned MAX_CONSEC = 4
) (
  input  logic              i_Clk,
  input  logic              i_Rst_n,
  input  logic [ADDR_W-1:0] i_M0_RegAddr,
  input  logic [3:0]        i_M0_ByteEn,
  input  logic              i_M0_Read,
  input  logic              i_M0_Write,
  input  logic [31:0]       i_M0_WriteData,
  output logic [31:0]       o_M0_ReadData,
  output logic              o_M0_ReadDataValid,
  output logic              o_M0_WaitRequest,
  input  logic [ADDR_W-1:0] i_M1_RegAddr,
  input  logic [3:0]        i_M1_ByteEn,
  input  logic              i_M1_Read,
  input  logic              i_M1_Write,
  input  logic [31:0]       i_M1_WriteData,
  output logic [31:0]       o_M1_ReadData,
  output logic              o_M1_ReadDataValid,
  output logic              o_M1_WaitRequest,
  output logic              o_Ram_SlaveSel,
  output logic [ADDR_W-1:0] o_Ram_RegAddr,
  output logic [3:0]        o_Ram_ByteEn,
  output logic              o_Ram_Read,
  output logic              o_Ram_Write,
  output logic [31:0]       o_Ram_WriteData,
  input  logic [31:0]       i_Ram_ReadData,
  input  logic              i_Ram_WaitRequest
);

  req_t m0_req, m1_req, sel_req;
  logic req0_c, req1_c, grant0_c, grant1_c, accept_c;
  logic rd_pend_q, rd_pend_d;
  logic rd_owner_q, rd_owner_d;

  // Pack each master's signals into a request bundle
  always_comb begin
    m0_req.addr   = ADDR_W_DEF'(i_M0_RegAddr);
    m0_req.byteen = i_M0_ByteEn;
    m0_req.read   = i_M0_Read;
    m0_req.write  = i_M0_Write;
    m0_req.wdata  = i_M0_WriteData;
    m1_req.addr   = ADDR_W_DEF'(i_M1_RegAddr);
    m1_req.byteen = i_M1_ByteEn;
    m1_req.read   = i_M1_Read;
    m1_req.write  = i_M1_Write;
    m1_req.wdata  = i_M1_WriteData;
  end

  assign req0_c = i_M0_Read | i_M0_Write;
  assign req1_c = i_M1_Read | i_M1_Write;

  rr_grant2 #(
    .FIXED_PRIO (FIXED_PRIO),
    .MAX_CONSEC (MAX_CONSEC)
  ) u_grant (
    .clk      (i_Clk),
    .rst_n    (i_Rst_n),
    .req0     (req0_c),
    .req1     (req1_c),
    .ram_wait (i_Ram_WaitRequest),
    .grant0_c (grant0_c),
    .grant1_c (grant1_c)
  );

  assign accept_c = (grant0_c | grant1_c) & ~i_Ram_WaitRequest;

  // RAM-side mux; everything is zero when nobody holds the grant
  always_comb begin
    sel_req = '0;
    if (grant0_c)      sel_req = m0_req;
    else if (grant1_c) sel_req = m1_req;
  end

  assign o_Ram_SlaveSel  = grant0_c | grant1_c;
  assign o_Ram_RegAddr   = ADDR_W'(sel_req.addr);
  assign o_Ram_ByteEn    = sel_req.byteen;
  assign o_Ram_Read      = sel_req.read;
  assign o_Ram_Write     = sel_req.write;
  assign o_Ram_WriteData = sel_req.wdata;

  assign o_M0_WaitRequest = req0_c & ~(grant0_c & ~i_Ram_WaitRequest);
  assign o_M1_WaitRequest = req1_c & ~(grant1_c & ~i_Ram_WaitRequest);

  // Response tracking: owner only moves on an accepted read, so a response
  // in flight and a new accept in the same cycle do not interfere.
  always_comb begin
    rd_pend_d  = accept_c & sel_req.read;
    rd_owner_d = rd_owner_q;
    if (accept_c && sel_req.read) rd_owner_d = grant1_c ? M1 : M0;
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      rd_pend_q  <= 1'b0;
      rd_owner_q <= M0;
    end else begin
      rd_pend_q  <= rd_pend_d;
      rd_owner_q <= rd_owner_d;
    end
  end

  assign o_M0_ReadDataValid = rd_pend_q & (rd_owner_q == M0);
  assign o_M1_ReadDataValid = rd_pend_q & (rd_owner_q == M1);
  assign o_M0_ReadData      = o_M0_ReadDataValid ? i_Ram_ReadData : 32'h0;
  assign o_M1_ReadData      = o_M1_ReadDataValid ? i_Ram_ReadData : 32'h0;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: a round-robin instance on a small RAM
// model and a fixed-priority instance for the starvation-cap pattern.
module tb_ram_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  // Round-robin instance
  logic [23:0] m0_addr, m1_addr;
  logic [3:0]  m0_be, m1_be;
  logic        m0_rd, m0_wr, m1_rd, m1_wr;
  logic [31:0] m0_wd, m1_wd;
  logic [31:0] m0_rdata, m1_rdata;
  logic        m0_rdv, m1_rdv, m0_wait, m1_wait;
  logic        ram_sel, ram_rd, ram_wr, ram_wait;
  logic [23:0] ram_addr;
  logic [3:0]  ram_be;
  logic [31:0] ram_wd, ram_rdata;

  // Fixed-priority instance
  logic        f0_rd, f1_rd;
  logic [31:0] f0_rdata, f1_rdata, f_ram_wd;
  logic        f0_rdv, f1_rdv, f0_wait, f1_wait;
  logic        f_ram_sel, f_ram_rd, f_ram_wr;
  logic [23:0] f_ram_addr;
  logic [3:0]  f_ram_be;

  ram_arbiter #(.ADDR_W(24), .FIXED_PRIO(0), .MAX_CONSEC(4)) dut_rr (
    .i_Clk(clk), .i_Rst_n(rst_n),
    .i_M0_RegAddr(m0_addr), .i_M0_ByteEn(m0_be), .i_M0_Read(m0_rd),
    .i_M0_Write(m0_wr), .i_M0_WriteData(m0_wd),
    .o_M0_ReadData(m0_rdata), .o_M0_ReadDataValid(m0_rdv), .o_M0_WaitRequest(m0_wait),
    .i_M1_RegAddr(m1_addr), .i_M1_ByteEn(m1_be), .i_M1_Read(m1_rd),
    .i_M1_Write(m1_wr), .i_M1_WriteData(m1_wd),
    .o_M1_ReadData(m1_rdata), .o_M1_ReadDataValid(m1_rdv), .o_M1_WaitRequest(m1_wait),
    .o_Ram_SlaveSel(ram_sel), .o_Ram_RegAddr(ram_addr), .o_Ram_ByteEn(ram_be),
    .o_Ram_Read(ram_rd), .o_Ram_Write(ram_wr), .o_Ram_WriteData(ram_wd),
    .i_Ram_ReadData(ram_rdata), .i_Ram_WaitRequest(ram_wait)
  );

  ram_arbiter #(.ADDR_W(24), .FIXED_PRIO(1), .MAX_CONSEC(4)) dut_fx (
    .i_Clk(clk), .i_Rst_n(rst_n),
    .i_M0_RegAddr(24'd1), .i_M0_ByteEn(4'hF), .i_M0_Read(f0_rd),
    .i_M0_Write(1'b0), .i_M0_WriteData(32'h0),
    .o_M0_ReadData(f0_rdata), .o_M0_ReadDataValid(f0_rdv), .o_M0_WaitRequest(f0_wait),
    .i_M1_RegAddr(24'd2), .i_M1_ByteEn(4'hF), .i_M1_Read(f1_rd),
    .i_M1_Write(1'b0), .i_M1_WriteData(32'h0),
    .o_M1_ReadData(f1_rdata), .o_M1_ReadDataValid(f1_rdv), .o_M1_WaitRequest(f1_wait),
    .o_Ram_SlaveSel(f_ram_sel), .o_Ram_RegAddr(f_ram_addr), .o_Ram_ByteEn(f_ram_be),
    .o_Ram_Read(f_ram_rd), .o_Ram_Write(f_ram_wr), .o_Ram_WriteData(f_ram_wd),
    .i_Ram_ReadData(32'h0), .i_Ram_WaitRequest(1'b0)
  );

  // RAM model: 16 words, byte-enabled writes, 1-cycle read latency,
  // preloaded while reset is low
  logic [31:0] mem [16];
  int n_wr;
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) mem[i] <= 32'h0;
      mem[1]    <= 32'h1111_1111;
      mem[2]    <= 32'h2222_2222;
      mem[5]    <= 32'hDEAD_BEEF;
      ram_rdata <= 32'h0;
      n_wr      <= 0;
    end else if (ram_sel && !ram_wait) begin
      if (ram_wr) begin
        for (int b = 0; b < 4; b++)
          if (ram_be[b]) mem[ram_addr[3:0]][8*b +: 8] <= ram_wd[8*b +: 8];
        n_wr <= n_wr + 1;
      end
      if (ram_rd) ram_rdata <= mem[ram_addr[3:0]];
    end
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic idle();
    m0_rd = 1'b0; m0_wr = 1'b0; m1_rd = 1'b0; m1_wr = 1'b0;
  endtask

  int wcnt;
  logic exp_g1, exp_m0v, exp_m1v;

  initial begin
    rst_n = 1'b0; ram_wait = 1'b0;
    m0_addr = '0; m1_addr = '0; m0_be = 4'hF; m1_be = 4'hF;
    m0_wd = '0; m1_wd = '0; f0_rd = 1'b0; f1_rd = 1'b0;
    idle();

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check_val("rst_m0_rdv", 32'(m0_rdv), 32'h0);
    check_val("rst_m1_rdv", 32'(m1_rdv), 32'h0);
    check_val("rst_m0_rdata", m0_rdata, 32'h0);
    check_val("rst_m1_rdata", m1_rdata, 32'h0);
    check_val("rst_ram_sel", 32'(ram_sel), 32'h0);
    @(negedge clk); rst_n = 1'b1;

    // Single M0 read of preloaded word
    @(negedge clk); m0_rd = 1'b1; m0_addr = 24'd5; #1;
    check_val("m0rd_ram_read", 32'(ram_rd), 32'h1);
    check_val("m0rd_ram_addr", 32'(ram_addr), 32'h5);
    check_val("m0rd_wait", 32'(m0_wait), 32'h0);
    @(negedge clk); m0_rd = 1'b0; #1;
    check_val("m0rd_rdv", 32'(m0_rdv), 32'h1);
    check_val("m0rd_rdata", m0_rdata, 32'hDEAD_BEEF);
    check_val("m0rd_m1_rdv", 32'(m1_rdv), 32'h0);
    check_val("m0rd_m1_rdata", m1_rdata, 32'h0);

    // Round-robin contention; last grant was M0, so M1 leads
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      m0_rd = 1'b1; m0_addr = 24'd1; m1_rd = 1'b1; m1_addr = 24'd2;
      #1;
      exp_g1  = (k % 2 == 0);
      exp_m0v = (k > 0) && (k % 2 == 0);
      exp_m1v = (k % 2 == 1);
      check_val("rr_m0_wait", 32'(m0_wait), 32'(exp_g1));
      check_val("rr_m1_wait", 32'(m1_wait), 32'(!exp_g1));
      check_val("rr_ram_addr", 32'(ram_addr), exp_g1 ? 32'h2 : 32'h1);
      check_val("rr_m0_rdv", 32'(m0_rdv), 32'(exp_m0v));
      check_val("rr_m1_rdv", 32'(m1_rdv), 32'(exp_m1v));
      check_val("rr_m0_rdata", m0_rdata, exp_m0v ? 32'h1111_1111 : 32'h0);
      check_val("rr_m1_rdata", m1_rdata, exp_m1v ? 32'h2222_2222 : 32'h0);
    end
    @(negedge clk); idle(); #1;
    check_val("rr_tail_m0_rdv", 32'(m0_rdv), 32'h1);
    check_val("rr_tail_m0_rdata", m0_rdata, 32'h1111_1111);
    check_val("rr_tail_m1_rdv", 32'(m1_rdv), 32'h0);

    // Fixed priority: M1 x4, then M0 once, repeating
    for (int k = 0; k < 10; k++) begin
      @(negedge clk); f0_rd = 1'b1; f1_rd = 1'b1; #1;
      check_val("fx_m1_wait", 32'(f1_wait), 32'(k % 5 == 4));
      check_val("fx_m0_wait", 32'(f0_wait), 32'(k % 5 != 4));
    end
    @(negedge clk); f0_rd = 1'b0; f1_rd = 1'b0;

    // RAM stall during an M1 partial write, with M0 also requesting
    @(negedge clk);
    ram_wait = 1'b1; wcnt = n_wr;
    m1_wr = 1'b1; m1_addr = 24'd3; m1_wd = 32'h1234_5678; m1_be = 4'b0011;
    m0_rd = 1'b1; m0_addr = 24'd4;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      check_val("stall_m0_wait", 32'(m0_wait), 32'h1);
      check_val("stall_m1_wait", 32'(m1_wait), 32'h1);
      check_val("stall_ram_write", 32'(ram_wr), 32'h1);
      check_val("stall_ram_addr", 32'(ram_addr), 32'h3);
      check_val("stall_ram_be", 32'(ram_be), 32'h3);
    end
    @(negedge clk); ram_wait = 1'b0; #1;
    check_val("rel_nwr", 32'(n_wr), 32'(wcnt));
    check_val("rel_m1_wait", 32'(m1_wait), 32'h0);
    check_val("rel_m0_wait", 32'(m0_wait), 32'h1);
    @(negedge clk); m1_wr = 1'b0; m1_be = 4'hF; #1;
    check_val("rel_nwr_once", 32'(n_wr), 32'(wcnt + 1));
    check_val("rel_m0_granted", 32'(m0_wait), 32'h0);
    check_val("rel_m0_addr", 32'(ram_addr), 32'h4);
    @(negedge clk); m0_rd = 1'b0; #1;
    check_val("rel_m0_rdv", 32'(m0_rdv), 32'h1);
    check_val("rel_m0_rdata", m0_rdata, 32'h0);
    check_val("rel_nwr_final", 32'(n_wr), 32'(wcnt + 1));
    @(negedge clk); m1_rd = 1'b1; m1_addr = 24'd3; #1;
    check_val("rb_m1_wait", 32'(m1_wait), 32'h0);
    @(negedge clk); m1_rd = 1'b0; #1;
    check_val("rb_m1_rdv", 32'(m1_rdv), 32'h1);
    check_val("rb_m1_rdata", m1_rdata, 32'h0000_5678);

    // M0 write then M1 read of the same word
    @(negedge clk); m0_wr = 1'b1; m0_addr = 24'd7; m0_wd = 32'hA5A5_A5A5; m0_be = 4'hF; #1;
    check_val("wr_m0_wait", 32'(m0_wait), 32'h0);
    check_val("wr_ram_write", 32'(ram_wr), 32'h1);
    @(negedge clk); m0_wr = 1'b0; m1_rd = 1'b1; m1_addr = 24'd7; #1;
    check_val("wr_m1_wait", 32'(m1_wait), 32'h0);
    @(negedge clk); m1_rd = 1'b0; #1;
    check_val("wr_m1_rdv", 32'(m1_rdv), 32'h1);
    check_val("wr_m1_rdata", m1_rdata, 32'hA5A5_A5A5);

    // Reset right after an accepted M1 read kills the response
    @(negedge clk); m1_rd = 1'b1; m1_addr = 24'd2; #1;
    check_val("rr_rst_m1_wait", 32'(m1_wait), 32'h0);
    @(posedge clk); #2; rst_n = 1'b0; idle();
    @(negedge clk); #1;
    check_val("rst_mid_m1_rdv", 32'(m1_rdv), 32'h0);
    check_val("rst_mid_m1_rdata", m1_rdata, 32'h0);
    check_val("rst_mid_m0_rdv", 32'(m0_rdv), 32'h0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    m0_rd = 1'b1; m0_addr = 24'd1; m1_rd = 1'b1; m1_addr = 24'd2; #1;
    check_val("post_rst_m0_wait", 32'(m0_wait), 32'h0);
    check_val("post_rst_m1_wait", 32'(m1_wait), 32'h1);
    check_val("post_rst_addr", 32'(ram_addr), 32'h1);
    @(negedge clk); idle(); #1;
    check_val("post_rst_m0_rdv", 32'(m0_rdv), 32'h1);
    check_val("post_rst_m0_rdata", m0_rdata, 32'h1111_1111);

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
